// File: rtl/cpuf_pkg.sv
// Shared CPU/fetch definitions: bus widths, opcode map, memory responder state and write payload.
package cpuf_pkg;

  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam int unsigned PROT_TOP = 7;

  localparam logic [3:0] OP_LDA = 4'b1000;
  localparam logic [3:0] OP_LDB = 4'b0100;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b1100;
  localparam logic [3:0] OP_DIV = 4'b1010;
  localparam logic [3:0] OP_JMP = 4'b1001;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_wr_t;

endpackage

// File: rtl/mem_array_1r1w.sv
// DEPTH x DATA_W storage, one synchronous read port (read-before-write) and one write port.
// Only the read data register is reset; the array contents survive reset.
module mem_array_1r1w
  import cpuf_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  input  mem_wr_t           i_wr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_wr.we) r_mem[i_wr.addr] <= i_wr.data;
  end

  // Same-edge write lands after this sample, so a colliding read sees the old word.
  always_ff @(posedge clk) begin
    if (reset)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/prog_mem_responder.sv
// Program/data memory: streams a program image in (LOAD), then serves CPU reads/writes (RUN).
// Optional macro WRITE_PROTECT_EN rejects RUN-time writes to addresses 0..PROT_TOP.
module prog_mem_responder
  import cpuf_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              reload,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              running
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_ld_ptr;
  logic [ADDR_W-1:0] w_ld_ptr_nxt;
  logic              w_ld_accept;
  logic              w_rd_fire;
  logic              w_wr_live;
  logic              w_wr_prot;
  logic              w_wr_fire;
  mem_wr_t           w_mem_wr;
  logic [DATA_W-1:0] w_rd_data;

  logic r_ld_ready;
  logic r_running;
  logic r_rd_ack;
  logic r_wr_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_LOAD;
      r_ld_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ld_ptr <= w_ld_ptr_nxt;
    end
  end

  // Next state, loader pointer and request qualification; reload in RUN drops this cycle's requests.
  always_comb begin
    w_state_nxt  = r_state;
    w_ld_ptr_nxt = r_ld_ptr;
    w_ld_accept  = 1'b0;
    w_rd_fire    = 1'b0;
    w_wr_live    = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_ld_accept = ld_valid;
        if (ld_valid) begin
          if (ld_last || (r_ld_ptr == ADDR_W'(DEPTH - 1))) begin
            w_state_nxt  = ST_RUN;
            w_ld_ptr_nxt = '0;
          end else begin
            w_ld_ptr_nxt = r_ld_ptr + ADDR_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (reload) begin
          w_state_nxt  = ST_LOAD;
          w_ld_ptr_nxt = '0;
        end else begin
          w_rd_fire = rd_req;
          w_wr_live = wr_req;
        end
      end
      default: begin
        w_state_nxt  = ST_LOAD;
        w_ld_ptr_nxt = '0;
      end
    endcase
  end

`ifdef WRITE_PROTECT_EN
  logic r_wr_err;

  assign w_wr_prot = (wr_addr <= ADDR_W'(PROT_TOP));

  always_ff @(posedge clk) begin
    if (reset) r_wr_err <= 1'b0;
    else       r_wr_err <= w_wr_live & w_wr_prot;
  end

  assign wr_err = r_wr_err;
`else
  assign w_wr_prot = 1'b0;
  assign wr_err    = 1'b0;
`endif

  assign w_wr_fire = w_wr_live & ~w_wr_prot;

  // Loader and CPU writes never coexist: the loader only writes in LOAD, the CPU only in RUN.
  always_comb begin
    w_mem_wr.we   = ~reset & (w_ld_accept | w_wr_fire);
    w_mem_wr.addr = w_ld_accept ? r_ld_ptr : wr_addr;
    w_mem_wr.data = w_ld_accept ? ld_data  : wr_data;
  end

  mem_array_1r1w u_mem (
    .clk     (clk),
    .reset   (reset),
    .i_re    (w_rd_fire),
    .i_raddr (rd_addr),
    .i_wr    (w_mem_wr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ld_ready <= 1'b1;
      r_running  <= 1'b0;
      r_rd_ack   <= 1'b0;
      r_wr_ack   <= 1'b0;
    end else begin
      r_ld_ready <= (w_state_nxt == ST_LOAD);
      r_running  <= (w_state_nxt == ST_RUN);
      r_rd_ack   <= w_rd_fire;
      r_wr_ack   <= w_wr_fire;
    end
  end

  assign ld_ready = r_ld_ready;
  assign running  = r_running;
  assign rd_ack   = r_rd_ack;
  assign rd_data  = w_rd_data;
  assign wr_ack   = r_wr_ack;

endmodule

// File: tb/tb_prog_mem_responder.sv
// Directed + random bench for prog_mem_responder against a cycle-level behavioural model.
module tb_prog_mem_responder;
  import cpuf_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, ld_valid, ld_last, reload, rd_req, wr_req;
  logic [DATA_W-1:0] ld_data, wr_data;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic              ld_ready, rd_ack, wr_ack, wr_err, running;
  logic [DATA_W-1:0] rd_data;

  prog_mem_responder dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .reload(reload),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .wr_err(wr_err),
    .running(running)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: memory image, which words hold defined data, mode, loader position.
  logic [7:0] m_mem   [16];
  bit         m_known [16];
  bit         m_run;
  int         m_ptr;
  bit         e_rd_ack, e_wr_ack, e_wr_err, e_rd_known;
  logic [7:0] e_rd_data;

  function automatic bit prot(input logic [3:0] a);
`ifdef WRITE_PROTECT_EN
    return (int'(a) <= 7);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Predict the effect of the inputs currently driven, clock once, compare every output.
  task automatic cyc();
    e_rd_ack = 1'b0;
    e_wr_ack = 1'b0;
    e_wr_err = 1'b0;
    if (reset) begin
      m_run = 1'b0; m_ptr = 0; e_rd_data = 8'h00; e_rd_known = 1'b1;
    end else if (!m_run) begin
      if (ld_valid) begin
        m_mem[m_ptr]   = ld_data;
        m_known[m_ptr] = 1'b1;
        if (ld_last || m_ptr == 15) begin m_run = 1'b1; m_ptr = 0; end
        else m_ptr = m_ptr + 1;
      end
    end else if (reload) begin
      m_run = 1'b0; m_ptr = 0;
    end else begin
      if (rd_req) begin
        e_rd_ack   = 1'b1;
        e_rd_data  = m_mem[rd_addr];
        e_rd_known = m_known[rd_addr];
      end
      if (wr_req) begin
        if (prot(wr_addr)) e_wr_err = 1'b1;
        else begin
          m_mem[wr_addr]   = wr_data;
          m_known[wr_addr] = 1'b1;
          e_wr_ack         = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("running",  32'(running),  32'(m_run));
    chk("ld_ready", 32'(ld_ready), 32'(!m_run));
    chk("rd_ack",   32'(rd_ack),   32'(e_rd_ack));
    chk("wr_ack",   32'(wr_ack),   32'(e_wr_ack));
    chk("wr_err",   32'(wr_err),   32'(e_wr_err));
    if (e_rd_known) chk("rd_data", 32'(rd_data), 32'(e_rd_data));
  endtask

  task automatic idle();
    reset = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0; reload = 1'b0;
    rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic ld(input logic [7:0] d, input bit last);
    idle(); ld_valid = 1'b1; ld_data = d; ld_last = last; cyc();
  endtask

  task automatic rd(input logic [3:0] a);
    idle(); rd_req = 1'b1; rd_addr = a; cyc();
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    idle(); wr_req = 1'b1; wr_addr = a; wr_data = d; cyc();
  endtask

  logic [7:0] img [6];

  initial begin
    for (int i = 0; i < 16; i++) m_known[i] = 1'b0;
    m_run = 1'b0; m_ptr = 0; e_rd_known = 1'b0; e_rd_data = '0;
    img[0] = 8'h00; img[1] = 8'h41; img[2] = 8'hFF;
    img[3] = 8'h02; img[4] = 8'h01; img[5] = 8'h89;

    idle(); reset = 1'b1; cyc(); cyc();

    // Requests during LOAD are dropped.
    rd(4'd0);
    wr(4'd1, 8'h33);

    for (int i = 0; i < 6; i++) ld(img[i], i == 5);
    idle(); cyc();
    for (int a = 0; a < 6; a++) rd(4'(a));
    idle(); cyc();

    for (int i = 0; i < 4; i++) rd(4'd2);
    idle(); cyc();

    // Colliding read and write: read sees the old word.
    idle(); wr_req = 1'b1; wr_addr = 4'd3; wr_data = 8'h5A; rd_req = 1'b1; rd_addr = 4'd3; cyc();
    rd(4'd3);
    wr(4'd4, 8'hAA); rd(4'd4);
    wr(4'd8, 8'h77); rd(4'd8);
    idle(); wr_req = 1'b1; wr_addr = 4'd9; wr_data = 8'h19; rd_req = 1'b1; rd_addr = 4'd5; cyc();
    rd(4'd9);

    // Reload wins over a same-cycle read.
    idle(); reload = 1'b1; rd_req = 1'b1; rd_addr = 4'd0; cyc();
    idle(); reload = 1'b1; cyc();

    // Full image without ld_last: wrap guard enters RUN.
    for (int i = 0; i < 16; i++) ld(8'($urandom), 1'b0);
    idle(); ld_valid = 1'b1; ld_data = 8'hEE; cyc();
    rd(4'd15); rd(4'd0);

    // Reset mid-load keeps words already written.
    idle(); reload = 1'b1; cyc();
    ld(8'hC1, 1'b0); ld(8'hC2, 1'b0); ld(8'hC3, 1'b0);
    idle(); reset = 1'b1; cyc();
    ld(8'hD0, 1'b1);
    rd(4'd0); rd(4'd1); rd(4'd2);

    for (int n = 0; n < 800; n++) begin
      idle();
      reset    = ($urandom_range(255) == 0);
      ld_valid = $urandom_range(1);
      ld_last  = ($urandom_range(7) == 0);
      ld_data  = 8'($urandom);
      reload   = ($urandom_range(31) == 0);
      rd_req   = $urandom_range(1);
      rd_addr  = 4'($urandom);
      wr_req   = ($urandom_range(2) == 0);
      wr_addr  = 4'($urandom);
      wr_data  = 8'($urandom);
      cyc();
    end

    idle(); cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
